// File: rtl/camera_window_capture.sv
// Purpose : crops a fixed H/V window out of a FVAL/LVAL-framed 10-bit raw Bayer stream and
//           latches per-frame geometry (last line width, line count, frame count, short flag).
// Latency : pixel sampled at edge n shows on oDATA/oDVAL after edge n+2; geometry one edge after f1 drops.
// Backpres: none; at most one pixel per clock and downstream must take every oDVAL beat.
// Ports   : iCLK/iRST_N clock and async active-low reset; iEN capture enable (taken at frame start);
//           iDATA/iFVAL/iLVAL camera input; oDATA/oDVAL/oSOF/oEOL/oEOF cropped stream with markers;
//           oFRAME_W/oFRAME_H/oFRAME_CNT/oSHORT geometry of the previous completed frame.
module camera_window_capture #(
   parameter int unsigned H_START  = 0,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned V_START  = 0,
   parameter int unsigned V_ACTIVE = 480
) (
   input  logic        iCLK,
   input  logic        iRST_N,
   input  logic        iEN,
   input  logic [9:0]  iDATA,
   input  logic        iFVAL,
   input  logic        iLVAL,
   output logic [9:0]  oDATA,
   output logic        oDVAL,
   output logic        oSOF,
   output logic        oEOL,
   output logic        oEOF,
   output logic [11:0] oFRAME_W,
   output logic [11:0] oFRAME_H,
   output logic [15:0] oFRAME_CNT,
   output logic        oSHORT
);

   localparam logic [12:0] HS = 13'(H_START);
   localparam logic [12:0] HA = 13'(H_ACTIVE);
   localparam logic [12:0] HE = 13'(H_START + H_ACTIVE);
   localparam logic [12:0] HL = 13'(H_START + H_ACTIVE - 1);
   localparam logic [12:0] VS = 13'(V_START);
   localparam logic [12:0] VA = 13'(V_ACTIVE);
   localparam logic [12:0] VE = 13'(V_START + V_ACTIVE);
   localparam logic [12:0] VL = 13'(V_START + V_ACTIVE - 1);

   typedef enum logic [1:0] {SYNC, IDLE, FRAME} state_t;

   function automatic logic [11:0] inc_sat(input logic [11:0] v);
      return (v == 12'hFFF) ? v : v + 12'd1;
   endfunction

   // input and edge-detect stages
   logic        f1_q, f1_d, l1_q, l1_d, f2_q, f2_d, l2_q, l2_d;
   logic [9:0]  d1_q, d1_d;
   // frame tracking
   state_t      state_q, state_d;
   logic        en_q, en_d;
   logic [11:0] x_q, x_d, y_q, y_d, lw_q, lw_d;
   // window decision stage
   logic        p_vld_q, p_vld_d, p_sof_q, p_sof_d, p_eol_q, p_eol_d, p_eof_q, p_eof_d;
   logic [9:0]  p_dat_q, p_dat_d;
   // output registers
   logic [9:0]  data_q, data_d;
   logic        dval_q, dval_d, sof_q, sof_d, eol_q, eol_d, eof_q, eof_d, short_q, short_d;
   logic [11:0] frame_w_q, frame_w_d, frame_h_q, frame_h_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   // combinational helpers
   logic        f_rise, l_rise, l_fall, start, active, en_eff, in_win;
   logic [11:0] x_base, y_base, lw_base, cur_x, h_close, w_close;
   logic [13:0] dx, dy;

   always_comb begin
      f1_d = iFVAL;
      l1_d = iLVAL;
      d1_d = iDATA;
      f2_d = f1_q;
      l2_d = l1_q;

      state_d = state_q;
      en_d    = en_q;
      x_d     = x_q;
      y_d     = y_q;
      lw_d    = lw_q;

      p_vld_d = 1'b0;
      p_dat_d = d1_q;
      p_sof_d = 1'b0;
      p_eol_d = 1'b0;
      p_eof_d = 1'b0;

      dval_d = p_vld_q;
      data_d = p_vld_q ? p_dat_q : data_q;
      sof_d  = p_sof_q;
      eol_d  = p_eol_q;
      eof_d  = p_eof_q;

      frame_w_d   = frame_w_q;
      frame_h_d   = frame_h_q;
      frame_cnt_d = frame_cnt_q;
      short_d     = 1'b0;

      f_rise = f1_q & ~f2_q;
      l_rise = l1_q & ~l2_q;
      l_fall = ~l1_q & l2_q;

      // The first cycle of a frame already counts as in-frame, with cleared counters and live iEN.
      start  = (state_q == IDLE) && f_rise;
      active = start || ((state_q == FRAME) && f1_q);
      en_eff = start ? iEN : en_q;

      x_base  = start ? 12'd0 : x_q;
      y_base  = start ? 12'd0 : y_q;
      lw_base = start ? 12'd0 : lw_q;
      cur_x   = l_rise ? 12'd0 : x_base;

      // Offsets from the window origin; bit 13 set means the pixel lies before the origin.
      dx     = {2'b00, cur_x}  - {1'b0, HS};
      dy     = {2'b00, y_base} - {1'b0, VS};
      in_win = active && l1_q && en_eff && !dx[13] && (dx[12:0] < HA) && !dy[13] && (dy[12:0] < VA);

      // A line still open when FVAL drops is counted as a completed line of its current length.
      h_close = l2_q ? inc_sat(y_q) : y_q;
      w_close = l2_q ? x_q : lw_q;

      case (state_q)
         SYNC:  if (!f1_q) state_d = IDLE;
         IDLE:  if (f_rise) state_d = FRAME;
         FRAME: if (!f1_q) begin
            state_d     = IDLE;
            frame_w_d   = w_close;
            frame_h_d   = h_close;
            frame_cnt_d = frame_cnt_q + 16'd1;
            short_d     = ({1'b0, h_close} < VE) || ({1'b0, w_close} < HE);
         end
         default: state_d = SYNC;
      endcase

      if (active) begin
         en_d    = en_eff;
         x_d     = l1_q ? inc_sat(cur_x) : x_base;
         y_d     = (l_fall && !start) ? inc_sat(y_q) : y_base;
         lw_d    = (l_fall && !start) ? x_q : lw_base;
         p_vld_d = in_win;
         p_sof_d = in_win && ({1'b0, cur_x} == HS) && ({1'b0, y_base} == VS);
         p_eol_d = in_win && ({1'b0, cur_x} == HL);
         p_eof_d = in_win && ({1'b0, cur_x} == HL) && ({1'b0, y_base} == VL);
      end
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         // FVAL history resets high so SYNC only leaves once a genuinely low FVAL has been sampled.
         f1_q        <= 1'b1;
         f2_q        <= 1'b1;
         l1_q        <= 1'b0;
         l2_q        <= 1'b0;
         d1_q        <= '0;
         state_q     <= SYNC;
         en_q        <= 1'b0;
         x_q         <= '0;
         y_q         <= '0;
         lw_q        <= '0;
         p_vld_q     <= 1'b0;
         p_dat_q     <= '0;
         p_sof_q     <= 1'b0;
         p_eol_q     <= 1'b0;
         p_eof_q     <= 1'b0;
         data_q      <= '0;
         dval_q      <= 1'b0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         eof_q       <= 1'b0;
         frame_w_q   <= '0;
         frame_h_q   <= '0;
         frame_cnt_q <= '0;
         short_q     <= 1'b0;
      end else begin
         f1_q        <= f1_d;
         f2_q        <= f2_d;
         l1_q        <= l1_d;
         l2_q        <= l2_d;
         d1_q        <= d1_d;
         state_q     <= state_d;
         en_q        <= en_d;
         x_q         <= x_d;
         y_q         <= y_d;
         lw_q        <= lw_d;
         p_vld_q     <= p_vld_d;
         p_dat_q     <= p_dat_d;
         p_sof_q     <= p_sof_d;
         p_eol_q     <= p_eol_d;
         p_eof_q     <= p_eof_d;
         data_q      <= data_d;
         dval_q      <= dval_d;
         sof_q       <= sof_d;
         eol_q       <= eol_d;
         eof_q       <= eof_d;
         frame_w_q   <= frame_w_d;
         frame_h_q   <= frame_h_d;
         frame_cnt_q <= frame_cnt_d;
         short_q     <= short_d;
      end
   end

   assign oDATA      = data_q;
   assign oDVAL      = dval_q;
   assign oSOF       = sof_q;
   assign oEOL       = eol_q;
   assign oEOF       = eof_q;
   assign oFRAME_W   = frame_w_q;
   assign oFRAME_H   = frame_h_q;
   assign oFRAME_CNT = frame_cnt_q;
   assign oSHORT     = short_q;

endmodule

// File: doc/camera_window_capture.md
# camera_window_capture

Pixel-clock-domain front end between the D8M MIPI bridge parallel output (10-bit raw Bayer, FVAL/LVAL framing) and the camera capture stream in the Qsys system. It aligns to whole frames, counts pixels and lines, crops a fixed active window, and emits a qualified pixel stream with start/end markers. It also latches per-frame geometry and flags short frames for the Nios status readback.

## Interface
- H_START, 0: first captured column (pixel index within line, 0-based)
- H_ACTIVE, 640: captured columns per line, ≥1
- V_START, 0: first captured line (0-based)
- V_ACTIVE, 480: captured lines per frame, ≥1
- iCLK  in  1  pixel clock (MIPI_PIXEL_CLK); sole clock
- iRST_N  in  1  reset, asynchronous assert, active-low
- iEN  in  1  capture enable, sampled only at frame start
- iDATA  in  10  raw pixel (MIPI_PIXEL_D[9:0])
- iFVAL  in  1  frame valid (MIPI_PIXEL_VS)
- iLVAL  in  1  line valid (MIPI_PIXEL_HS); pixel valid when iFVAL&iLVAL
- oDATA  out  10  cropped pixel
- oDVAL  out  1  oDATA valid
- oSOF  out  1  with first pixel of window
- oEOL  out  1  with last pixel of each window line
- oEOF  out  1  with last pixel of window
- oFRAME_W  out  12  pixels in last line of previous frame
- oFRAME_H  out  12  lines in previous frame
- oFRAME_CNT  out  16  completed-frame counter, wraps
- oSHORT  out  1  one-cycle pulse: completed frame smaller than window

## Operation
- Stage 1 registers iDATA/iFVAL/iLVAL (f1, l1, d1); stage 2 holds previous f2, l2 for edge detection.
- FSM: SYNC (reset state; wait f1=0) -> IDLE (wait f1 rising) -> FRAME (f1 high) -> IDLE on f1 falling. SYNC guarantees a frame already in progress at reset release is discarded.
- On IDLE->FRAME: capture iEN into en_q; clear x, y, max tracking. en_q=0: frame counted and measured but no oDVAL/oSOF/oEOL/oEOF.
- x (12b): index of current pixel; cleared on l1 rising, +1 per pixel with l1=1; saturates at 4095.
- y (12b): line index; +1 on l1 falling while FRAME; saturates at 4095.
- Pixel in window iff l1 & en_q & H_START ≤ x < H_START+H_ACTIVE & V_START ≤ y < V_START+V_ACTIVE.
- oSOF: in window & x=H_START & y=V_START. oEOL: x=H_START+H_ACTIVE-1. oEOF: oEOL & y=V_START+V_ACTIVE-1.
- On f1 falling (FRAME->IDLE): oFRAME_W <= last completed line length (x count at last l1 falling); oFRAME_H <= y (lines completed; a line still open when f1 drops counts as one); oFRAME_CNT +1 mod 2^16; oSHORT pulses if oFRAME_H < V_START+V_ACTIVE or oFRAME_W < H_START+H_ACTIVE.
- l1 high while f1 low: ignored entirely.
- Frames ending before the window completes produce no oEOF; downstream relies on oSOF to resync.
- Window bounds are compile-time constants; sums computed at 13 bits, no overflow.

## Timing
- Reset values: oDATA=0, oDVAL=0, oSOF=0, oEOL=0, oEOF=0, oFRAME_W=0, oFRAME_H=0, oFRAME_CNT=0, oSHORT=0; FSM=SYNC; all counters 0.
- Latency: input pixel at edge n appears on oDATA/oDVAL at edge n+2; markers aligned with their pixel.
- oDATA holds last value when oDVAL=0.
- Geometry registers and oSHORT update 2 cycles after iFVAL falls at input; stable until next frame end.
- Reset mid-frame: outputs clear immediately (async); after release, no output until next complete frame (SYNC).
- iEN change mid-frame has no effect until next frame start.
- No backpressure: one pixel per clock maximum, downstream must accept every oDVAL.

## Test plan
- Params H_START=2,H_ACTIVE=4,V_START=1,V_ACTIVE=2; frame of 3 lines×8 pixels, data=line*16+col, iEN=1 -> 8 oDVAL pixels 0x12..0x15, 0x22..0x25; oSOF with 0x12, oEOL with 0x15 and 0x25, oEOF with 0x25; oFRAME_W=8, oFRAME_H=3, oFRAME_CNT=1, no oSHORT.
- Latency check: single pixel at col 2 line 1 -> oDVAL exactly 2 clocks after input edge.
- Release reset with iFVAL=1 mid-frame -> no oDVAL, oFRAME_CNT stays 0; following full frame captured normally, oFRAME_CNT=1.
- Frame of 2 lines×5 pixels -> oSHORT one-cycle pulse, oFRAME_W=5, oFRAME_H=2, no oEOF.
- iEN=0 at frame start, raised mid-frame -> zero oDVAL that frame, geometry/counter still update; next frame captured.
- 65536 short frames (or force counter) -> oFRAME_CNT wraps 0xFFFF->0x0000; asserting iRST_N=0 mid-line clears all outputs within the same cycle.
